ar_seq_ctrl: RTL and testbench
==============================

Name: ar_seq_ctrl

Overview:
- Sequencer for the AR MAC datapath. Owns its 2-bit control bus: 00 run, 01 stall, 10 init, 11 clear.
- Takes a configure command with an order, clears the datapath, then walks it through coefficient latch and history priming. After that it streams samples with a valid/ready handshake on both sides.
- Sits between the sample source, the config registers and the AR block. Coefficients wire straight from the config registers to the datapath.

Parameters:
- DW, 32, sample width (Q15 fixed point, passed through untouched)
- MAX_ORDER, 9, largest legal order; the datapath adder chain supports 1..9 only

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle pulse: (re)configure with cfg_p_order
- cfg_p_order  in  32  requested order, sampled on cfg_start
- cfg_stop  in  1  pulse: return to IDLE, datapath history retained
- cfg_err  out  1  one-cycle pulse: cfg_start rejected
- in_data  in  DW  sample from source
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted this cycle when in_valid=1
- ar_control  out  2  datapath control bus
- ar_data_in  out  DW  datapath sample input, equals in_data (combinational)
- ar_p_order  out  32  registered order to datapath p_order_in
- out_valid  out  1  datapath data_out holds a fresh prediction
- out_ready  in  1  downstream accepts prediction
- busy  out  1  high in CLEAR/LOAD/PRIME

Behaviour:
- Reset state CLEAR. During and after rst: ar_control=11, in_ready=0, out_valid=0, cfg_err=0, ar_p_order=0, busy=1, prime_cnt=0.
- States: CLEAR, IDLE, LOAD, PRIME, RUN. ar_control is decoded combinationally from the state plus the accept term. in_ready is combinational.
- CLEAR: ar_control=11 for exactly one cycle, then goes to LOAD if a start is pending, else IDLE.
- IDLE: ar_control=01, in_ready=0.
  - cfg_start with order in 1..MAX_ORDER: latch ar_p_order, set prime_cnt=order, go to CLEAR with start pending.
  - cfg_start with order 0 or >MAX_ORDER: cfg_err pulses the next cycle; state stays IDLE and ar_p_order is unchanged.
- LOAD: ar_control=10 for one cycle; the datapath latches coefficients and order here. in_ready=0. Next state PRIME.
- PRIME:
  - in_valid=1: ar_control=10, in_ready=1, prime_cnt decrements.
  - in_valid=0: ar_control=01, in_ready=0.
  - The accept that takes prime_cnt from 1 to 0 moves the state to RUN.
  - Exactly order accepts occur in PRIME, matching the datapath's init count. No out_valid is produced in PRIME.
- RUN:
  - accept = in_valid && (!out_valid || out_ready).
  - On accept: ar_control=00 and in_ready=1; out_valid is set next cycle, since the datapath registers the prediction from the pre-shift history.
  - Otherwise ar_control=01 (data_out holds) and in_ready=0.
  - out_valid clears on out_ready unless a new accept occurred in the same cycle; in that case it stays 1.
  - Every accepted sample yields exactly one prediction; no prediction is dropped or duplicated.
- cfg_start outside IDLE (any state): abort the current sequence and clear out_valid.
  - Legal order: go to CLEAR with start pending.
  - Illegal order: cfg_err pulses, then go to CLEAR followed by IDLE.
- cfg_stop in LOAD/PRIME/RUN: go to IDLE next cycle and clear out_valid. cfg_start has priority when both are high.
- Async rst mid-sequence: all outputs return to reset values immediately. The first clk edge after release drives a clear into the datapath.
- in_ready never asserts in CLEAR/LOAD/IDLE.
- ar_data_in is don't-care whenever ar_control is 01 or 11.

Test Plan:
- Reset release: rst high 3 cycles, then low -> ar_control=11 for one cycle, then 01 (IDLE); busy=0; out_valid=0.
- Configure and prime, order=2, coef0=16384, coef1=8192:
  - cfg_start -> one cycle of 11 (CLEAR), one cycle of 10 with in_ready=0 (LOAD).
  - Feed 32768, 65536 -> two cycles of 10 with in_ready=1, then RUN.
  - Feed 0 -> ar_control=00, one cycle later out_valid=1 and data_out=40960.
- PRIME gaps: order=3, in_valid toggled 1,0,1,0,1 -> ar_control 10,01,10,01,10, then RUN; exactly 3 accepts.
- Backpressure: in RUN hold out_ready=0 with in_valid=1 -> in_ready=0 and ar_control=01 after the first prediction; data_out is stable. Raise out_ready -> one accept per cycle, one prediction per accept.
- Illegal order: cfg_start with order 0, then with order 10 -> cfg_err pulses each time; ar_p_order unchanged; state stays IDLE.
- Reconfigure and reset mid-run:
  - cfg_start (order 1) during RUN with out_valid=1 -> out_valid=0 next cycle, CLEAR, LOAD, one prime accept, RUN.
  - rst asserted during PRIME -> ar_control=11 immediately.

Source files
------------

// File: rtl/ar_seq_ctrl.sv
// Sequencer for the AR MAC datapath: clear, coefficient load, history priming, then streaming.
// Control bus and in_ready are decoded combinationally from state; out_valid tracks one prediction per accepted RUN sample.
module ar_seq_ctrl #(
    parameter int DW        = 32,
    parameter int MAX_ORDER = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [31:0]   cfg_p_order,
    input  logic          cfg_stop,
    output logic          cfg_err,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    ar_control,
    output logic [DW-1:0] ar_data_in,
    output logic [31:0]   ar_p_order,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CW = $clog2(MAX_ORDER + 1);

    localparam logic [1:0] CTL_RUN   = 2'b00;
    localparam logic [1:0] CTL_STALL = 2'b01;
    localparam logic [1:0] CTL_INIT  = 2'b10;
    localparam logic [1:0] CTL_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_RUN
    } state_t;

    state_t          r_state;
    logic            r_start_pend;
    logic [CW-1:0]   r_prime_cnt;
    logic [31:0]     r_p_order;
    logic            r_out_valid;
    logic            r_cfg_err;

    logic            w_order_ok;
    logic            w_accept;
    logic            w_stoppable;

    assign w_order_ok  = (cfg_p_order != 32'd0) && (cfg_p_order <= 32'(MAX_ORDER));
    // A RUN accept needs room for the new prediction: either none pending or the pending one leaves now.
    assign w_accept    = in_valid && (!r_out_valid || out_ready);
    assign w_stoppable = (r_state == S_LOAD) || (r_state == S_PRIME) || (r_state == S_RUN);

    always_comb begin
        ar_control = CTL_STALL;
        in_ready   = 1'b0;
        case (r_state)
            S_CLEAR: ar_control = CTL_CLEAR;
            S_IDLE:  ar_control = CTL_STALL;
            S_LOAD:  ar_control = CTL_INIT;
            S_PRIME: begin
                ar_control = in_valid ? CTL_INIT : CTL_STALL;
                in_ready   = in_valid;
            end
            S_RUN: begin
                ar_control = w_accept ? CTL_RUN : CTL_STALL;
                in_ready   = w_accept;
            end
            default: ar_control = CTL_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_start_pend <= 1'b0;
            r_prime_cnt  <= '0;
            r_p_order    <= '0;
            r_out_valid  <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (cfg_start) begin
                if (w_order_ok) begin
                    r_p_order    <= cfg_p_order;
                    r_prime_cnt  <= cfg_p_order[CW-1:0];
                    r_start_pend <= 1'b1;
                    r_state      <= S_CLEAR;
                    r_out_valid  <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                    // A rejected start while idle leaves the datapath untouched.
                    if (r_state != S_IDLE) begin
                        r_start_pend <= 1'b0;
                        r_state      <= S_CLEAR;
                        r_out_valid  <= 1'b0;
                    end
                end
            end else if (cfg_stop && w_stoppable) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_state      <= r_start_pend ? S_LOAD : S_IDLE;
                        r_start_pend <= 1'b0;
                    end
                    S_LOAD:  r_state <= S_PRIME;
                    S_PRIME: begin
                        if (in_valid) begin
                            r_prime_cnt <= r_prime_cnt - CW'(1);
                            if (r_prime_cnt == CW'(1)) begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            r_out_valid <= 1'b1;
                        end else if (out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ar_data_in = in_data;
    assign ar_p_order = r_p_order;
    assign out_valid  = r_out_valid;
    assign cfg_err    = r_cfg_err;
    assign busy       = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_PRIME);

endmodule

// File: tb/tb_ar_seq_ctrl.sv
// Bench for ar_seq_ctrl: directed sequences plus random traffic against a phase-level reference model.
module tb_ar_seq_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start;
    logic [31:0]   cfg_p_order;
    logic          cfg_stop;
    logic          cfg_err;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ar_control;
    logic [DW-1:0] ar_data_in;
    logic [31:0]   ar_p_order;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    always #5 clk = ~clk;

    ar_seq_ctrl #(.DW(DW), .MAX_ORDER(9)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_p_order(cfg_p_order), .cfg_stop(cfg_stop), .cfg_err(cfg_err),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ar_control(ar_control), .ar_data_in(ar_data_in), .ar_p_order(ar_p_order),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase name, primes still owed, pending start, latched order, prediction pending.
    string m_ph;
    bit    m_pend;
    int    m_cnt;
    int    m_ord;
    bit    m_ov;
    bit    m_err;
    bit    last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = "CLR"; m_pend = 0; m_cnt = 0; m_ord = 0; m_ov = 0; m_err = 0;
    endtask

    task automatic set_idle();
        cfg_start = 0; cfg_p_order = 0; cfg_stop = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
    endtask

    task automatic step();
        int  e_ctl;
        bit  e_rdy;
        bit  acc;
        bit  legal;
        #1;
        if (rst) model_reset();
        acc   = in_valid && (!m_ov || out_ready);
        e_rdy = 0;
        if (m_ph == "CLR")      e_ctl = 3;
        else if (m_ph == "IDL") e_ctl = 1;
        else if (m_ph == "LD")  e_ctl = 2;
        else if (m_ph == "PR") begin e_ctl = in_valid ? 2 : 1; e_rdy = in_valid; end
        else                   begin e_ctl = acc ? 0 : 1;      e_rdy = acc;      end
        chk("ar_control", ar_control, e_ctl);
        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("cfg_err", cfg_err, m_err);
        chk("ar_p_order", ar_p_order, m_ord);
        chk("busy", busy, (m_ph == "CLR" || m_ph == "LD" || m_ph == "PR"));
        if (e_ctl == 0 || e_ctl == 2) chk("ar_data_in", ar_data_in, in_data);
        last_acc = in_valid && in_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_err = 0;
            legal = (cfg_p_order >= 1) && (cfg_p_order <= 9);
            if (cfg_start) begin
                if (legal) begin
                    m_ord = int'(cfg_p_order); m_cnt = m_ord; m_ph = "CLR"; m_pend = 1; m_ov = 0;
                end else begin
                    m_err = 1;
                    if (m_ph != "IDL") begin m_ph = "CLR"; m_pend = 0; m_ov = 0; end
                end
            end else if (cfg_stop && (m_ph == "LD" || m_ph == "PR" || m_ph == "RN")) begin
                m_ph = "IDL"; m_ov = 0;
            end else if (m_ph == "CLR") begin
                m_ph = m_pend ? "LD" : "IDL"; m_pend = 0;
            end else if (m_ph == "LD") begin
                m_ph = "PR";
            end else if (m_ph == "PR") begin
                if (in_valid) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_ph = "RN";
                end
            end else if (m_ph == "RN") begin
                if (acc) m_ov = 1;
                else if (out_ready) m_ov = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic start(input int ord);
        cfg_start = 1; cfg_p_order = ord; step();
        cfg_start = 0; cfg_p_order = 0;
    endtask

    task automatic feed(input logic v, input logic [DW-1:0] d, input logic ordy);
        in_valid = v; in_data = d; out_ready = ordy; step();
    endtask

    int prime_acc;

    initial begin
        set_idle();
        model_reset();
        #2 rst = 1;
        @(negedge clk);
        repeat (3) step();
        rst = 0;
        step();                                 // CLEAR pulse
        step();                                 // IDLE
        chk("idle_busy", busy, 0);

        // Configure order 2, prime with two samples, then one RUN sample.
        start(2);
        step(); step();                         // CLEAR, LOAD
        feed(1, 32768, 0);
        feed(1, 65536, 0);
        feed(1, 0, 0);                          // RUN accept
        feed(0, 0, 0);                          // prediction pending
        chk("pred_valid", out_valid, 1);
        feed(0, 0, 1);
        feed(0, 0, 0);

        // PRIME with gaps: order 3, valid pattern 1,0,1,0,1.
        start(3);
        step(); step();
        prime_acc = 0;
        for (int i = 0; i < 5; i++) begin
            feed(((i % 2) == 0), 32'(100 + i), 0);
            if (last_acc) prime_acc++;
        end
        chk("prime_accepts", prime_acc, 3);
        chk("prime_to_run_busy", busy, 0);

        // Backpressure then release.
        for (int i = 0; i < 4; i++) feed(1, 32'(200 + i), 0);
        for (int i = 0; i < 4; i++) feed(1, 32'(300 + i), 1);
        feed(0, 0, 1);
        feed(0, 0, 0);

        // Illegal orders while idle.
        cfg_stop = 1; step(); cfg_stop = 0;
        step();
        start(0); step();
        start(10); step();
        chk("illegal_keeps_order", ar_p_order, 3);

        // Reconfigure during RUN with a pending prediction.
        start(1);
        step(); step();
        feed(1, 7, 0);                          // single prime
        feed(1, 8, 0);                          // RUN accept
        feed(0, 0, 0);
        chk("run_pending", out_valid, 1);
        start(1);
        chk("reconf_clears_valid", out_valid, 0);
        step(); step();
        feed(1, 9, 0);
        feed(1, 10, 1);
        feed(0, 0, 1);

        // Async reset during PRIME.
        start(5);
        step(); step();
        feed(1, 11, 0);
        rst = 1; #1;
        chk("rst_immediate_ctl", ar_control, 3);
        step();
        rst = 0;
        step(); step();

        // Random traffic, including stray starts, stops and illegal orders.
        for (int i = 0; i < 3000; i++) begin
            cfg_start   = ($urandom_range(0, 39) == 0);
            cfg_p_order = $urandom_range(0, 11);
            cfg_stop    = ($urandom_range(0, 59) == 0);
            in_valid    = $urandom_range(0, 1);
            in_data     = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
